ripple_count_monitor: RTL
=========================

Name: ripple_count_monitor

Overview:
- Downstream consumer of the 3-bit asynchronous T-flip-flop up/down ripple counter.
- Brings the counter's glitchy ripple outputs and its mode bit into the system clock domain, and accepts only values that have settled.
- Checks each settled step against the counting direction. Reports the committed count, wrap events, illegal steps and a saturating error total.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each synchronizer for in_q and in_m (range 2..4).
- STABLE_CYCLES, 2, consecutive identical synchronized samples required to commit a value (range 2..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- in_clk  input  1  system clock; all state updates on its rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_q  input  3  ripple counter output; asynchronous to in_clk and glitchy during ripple.
- in_m  input  1  counter mode: 1 = up, 0 = down (matches counter convention); asynchronous.
- in_clr  input  1  synchronous clear of o_err_cnt.
- o_count  output  3  last committed, settled count.
- o_valid  output  1  one-cycle pulse when o_count is committed.
- o_wrap  output  1  one-cycle pulse on a legal wrap: 7->0 when up, 0->7 when down.
- o_err  output  1  one-cycle pulse when a committed step is not the expected +/-1.
- o_err_cnt  output  ERR_W  saturating count of o_err pulses.
- o_init_done  output  1  level; 1 once the first baseline is committed.

Behaviour:
- Reset (in_rst_n low, asynchronous): all outputs, synchronizer flops, the candidate register, the stability counter and the FSM go to 0 / S_INIT.
- Synchronizers: in_q (3 bits, per-bit) and in_m each pass through SYNC_STAGES flops. Their outputs are s_q and s_m.
- FSM states and transitions:
  - S_INIT:
    - cand tracks s_q.
    - cnt counts consecutive cycles with s_q == cand, and restarts at 1 when s_q changes.
    - When the count reaches STABLE_CYCLES: o_count <= cand, o_valid = 1, o_init_done <= 1, go to S_TRACK.
    - No wrap or err check is made on this first commit.
  - S_TRACK:
    - If s_q != o_count: cand <= s_q, cnt <= 1, go to S_SETTLE.
    - Otherwise stay.
  - S_SETTLE, checks in priority order:
    - s_q == o_count (glitch returned): go to S_TRACK, no pulses.
    - s_q != cand: cand <= s_q, cnt <= 1.
    - Otherwise cnt <= cnt+1. If cnt+1 == STABLE_CYCLES, commit and go to S_TRACK.
- Commit from S_SETTLE:
  - Step arithmetic: delta = (cand - o_count) mod 8.
  - Expected step: delta == 1 if s_m == 1; delta == 7 if s_m == 0. s_m is sampled on the commit edge.
  - Legal step: o_valid = 1. o_wrap = 1 if the step is 7->0 (up) or 0->7 (down).
  - Illegal step (including a direction mismatch or a skipped value): o_valid = 1, o_err = 1, o_wrap = 0.
  - o_count <= cand in both cases; the new value becomes the baseline.
- Latency: a clean in_q change arriving before edge k produces outputs visible after edge k + SYNC_STAGES + STABLE_CYCLES - 1. With defaults, a change before edge 1 yields o_valid after edge 4.
- All pulses are registered, high for exactly one cycle, and never asserted in back-to-back cycles. Each commit needs at least STABLE_CYCLES cycles of settling.
- o_err_cnt:
  - Increments on each o_err pulse and saturates at 2^ERR_W-1.
  - in_clr clears it to 0. If in_clr and an error occur on the same edge, the clear wins, the result is 0, and o_err is still pulsed.
- Reset mid-settle: the candidate is discarded. After release, the block re-enters S_INIT and requires a fresh baseline; o_init_done drops to 0.
- in_m toggling mid-settle: only the value of s_m at the commit edge matters.

Test Plan:
- Reset release with in_q=0 held, in_m=1 -> o_valid pulse after edge 4, o_count=0, o_init_done=1, o_err=0, o_wrap=0.
- Up sequence 0->1->...->7->0, each value held 10 cycles, in_m=1 -> 8 o_valid pulses, one o_wrap on 7->0, o_err_cnt=0, o_count=0 at end.
- Down sequence 0->7->6, in_m=0 -> o_wrap on 0->7 only, no errors, o_count=6.
- Ripple glitch 3->2->0->4, with 2 and 0 each held 1 cycle, then 4 stable, in_m=1 -> exactly one o_valid, o_count=4, o_err=0.
- Glitch 5->6 for 1 cycle then back to 5 -> no pulses, o_count stays 5.
- Illegal step 2->5 with in_m=1 -> o_err pulse, o_err_cnt=1, o_count=5. Then in_clr together with illegal step 5->0 -> o_err pulse, o_err_cnt=0. With ERR_W=2, 5 illegal steps -> o_err_cnt saturates at 3.

Source files
------------

// File: rtl/ripple_count_monitor.sv
// ============================================================================
// ripple_count_monitor : settles and step-checks a 3-bit async ripple counter
// Rev 1.0
// ============================================================================
`default_nettype none

module ripple_count_monitor #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 2,
   parameter int ERR_W         = 8
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic [2:0]       in_q,
   input  logic             in_m,
   input  logic             in_clr,
   output logic [2:0]       o_count,
   output logic             o_valid,
   output logic             o_wrap,
   output logic             o_err,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic             o_init_done
);

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_TRACK  = 2'd1,
      S_SETTLE = 2'd2
   } state_t;

   localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

   logic [SYNC_STAGES-1:0][2:0] sync_q_q;
   logic [SYNC_STAGES-1:0]      sync_m_q;
   logic [SYNC_STAGES-1:0]      prime_q;
   logic [2:0]                  s_q;
   logic                        s_m;
   logic                        s_valid;

   state_t           state_q, state_d;
   logic [2:0]       cand_q, cand_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [2:0]       count_q, count_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic             init_q, init_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic [3:0]       cnt_inc;
   logic [2:0]       delta;
   logic             step_ok;

   // prime_q marks when the synchronizer holds real samples rather than reset zeros
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         sync_q_q <= '0;
         sync_m_q <= '0;
         prime_q  <= '0;
      end else begin
         sync_q_q <= {sync_q_q[SYNC_STAGES-2:0], in_q};
         sync_m_q <= {sync_m_q[SYNC_STAGES-2:0], in_m};
         prime_q  <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign s_q     = sync_q_q[SYNC_STAGES-1];
   assign s_m     = sync_m_q[SYNC_STAGES-1];
   assign s_valid = prime_q[SYNC_STAGES-1];

   assign cnt_inc = cnt_q + 4'd1;
   assign delta   = cand_q - count_q;
   assign step_ok = s_m ? (delta == 3'd1) : (delta == 3'd7);

   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      count_d   = count_q;
      valid_d   = 1'b0;
      wrap_d    = 1'b0;
      err_d     = 1'b0;
      init_d    = init_q;
      err_cnt_d = err_cnt_q;

      case (state_q)
         S_INIT: begin
            if (s_valid) begin
               if (cnt_q == 4'd0 || s_q != cand_q) begin
                  cand_d = s_q;
                  cnt_d  = 4'd1;
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == STABLE_N) begin
                     count_d = cand_q;
                     valid_d = 1'b1;
                     init_d  = 1'b1;
                     state_d = S_TRACK;
                  end
               end
            end
         end
         S_TRACK: begin
            if (s_q != count_q) begin
               cand_d  = s_q;
               cnt_d   = 4'd1;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (s_q == count_q) begin
               state_d = S_TRACK;
            end else if (s_q != cand_q) begin
               cand_d = s_q;
               cnt_d  = 4'd1;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == STABLE_N) begin
                  count_d = cand_q;
                  valid_d = 1'b1;
                  state_d = S_TRACK;
                  if (step_ok) begin
                     wrap_d = s_m ? (count_q == 3'd7) : (count_q == 3'd0);
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_INIT;
      endcase

      // Clear takes precedence over a simultaneous error
      if (in_clr) begin
         err_cnt_d = '0;
      end else if (err_d && err_cnt_q != {ERR_W{1'b1}}) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q   <= S_INIT;
         cand_q    <= '0;
         cnt_q     <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
         init_q    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
         init_q    <= init_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_count     = count_q;
   assign o_valid     = valid_q;
   assign o_wrap      = wrap_q;
   assign o_err       = err_q;
   assign o_err_cnt   = err_cnt_q;
   assign o_init_done = init_q;

endmodule

`default_nettype wire
